link_stack: RTL and testbench
=============================

Name: link_stack

Overview:
- Hardware return-address stack that feeds the `rl` input of the program counter.
- On a subroutine call (`jump2sub`) it pushes the return address, `rp`+1. On a return (`retFsub`) it presents the saved address on `rl` and pops it.
- Sits beside the program counter in the fetch loop. It is driven by the same decoder strobes and uses the same priority as the PC, so stack state always matches what the PC actually did.

Parameters:
- DEPTH, 4, number of return-address entries; power of two, 2..16.
- AW, 10, address width of `rp`/`rl`.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- start  input  1  synchronous active-high reset; same signal that loads `start_address` into the PC.
- branch  input  1  decoder branch strobe; outranks `jump2sub`/`retFsub`, matching PC priority.
- jump2sub  input  1  call strobe; PC loads subroutine address on the same edge.
- retFsub  input  1  return strobe; PC loads `rl` on the same edge.
- rp  input  AW  current PC value, i.e. the address of the instruction now executing.
- rl  output  AW  top-of-stack return address; combinational from registered state.
- depth  output  5  number of valid entries, 0..DEPTH.
- empty  output  1  depth==0.
- full  output  1  depth==DEPTH.
- overflow  output  1  sticky: a push occurred while full.
- underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Storage: circular buffer `mem[DEPTH]` of AW bits, top pointer `top` (log2 DEPTH bits), count `depth`.
- Reset (`start`=1 at posedge): all `mem`=0, `top`=0, `depth`=0, `overflow`=0, `underflow`=0. All strobes are ignored while `start`=1.
- Reset mid-operation discards all entries. On the cycle after reset: `rl`=0, `empty`=1.
- Effective strobes:
  - push = !start & !branch & jump2sub
  - pop = !start & !branch & !jump2sub & retFsub
  - This mirrors the PC's branch > jump2sub > retFsub order. lj0..lj3 are lower priority in the PC and are not inputs here.
- Push:
  - `top` <= `top`+1 (mod DEPTH).
  - `mem[top+1]` <= `rp`+1, truncated to AW bits, so 10'h3FF pushes 10'h000.
  - `depth` <= min(`depth`+1, DEPTH).
- Push while full: the oldest entry is overwritten (circular), `depth` stays DEPTH, and `overflow` is set to 1.
- Pop:
  - `top` <= `top`-1 (mod DEPTH).
  - `depth` <= `depth`-1.
  - The PC samples `rl` on the same edge, so `rl` must already hold the value being popped during that cycle (zero-latency read).
- Pop while empty: `top` and `depth` are unchanged, `rl` presents 0, and `underflow` is set to 1.
- `rl` = (`depth`==0) ? 0 : `mem[top]`. It is purely combinational from registers, with no path from the strobes.
- Push and pop strobes together: push wins and pop is ignored, matching the PC.
- `branch` asserted: no state change, whatever the other strobes are.
- Sticky flags clear only on `start`.
- Latency: a pushed address is visible on `rl` in the cycle after the push edge. Back-to-back call then return works with 0 bubble cycles.

Test Plan:
- Reset then idle -> `rl`=0, `depth`=0, `empty`=1, `full`=0, both flags 0.
- `rp`=10'h012, pulse `jump2sub`; next cycle pulse `retFsub` -> `rl`=10'h013 during the `retFsub` cycle; afterwards `depth`=0 and `rl`=0.
- Nested calls at `rp`=10'h010, 10'h120, 10'h230, then three returns -> `rl` reads 10'h231, 10'h121, 10'h011 in order; `depth` goes 3,2,1,0.
- DEPTH=4: five pushes at `rp`=1..5 -> `full`=1, `overflow`=1, `depth`=4. Four pops read 6,5,4,3; the value 2 is lost.
- Pop when empty -> `underflow`=1, `depth`=0, `rl`=0. A following push at `rp`=10'h3FF -> `rl`=10'h000, `depth`=1.
- `branch`=1 with `jump2sub`=1 -> no push. `jump2sub`=1 with `retFsub`=1 at `rp`=10'h040 -> push 10'h041, no pop. Assert `start` with `depth`=3 -> next cycle `depth`=0 and flags clear.

Source files
------------

// File: rtl/link_stack_if.sv
// Strobe/address bundle between the decoder/PC side and the return-address stack.
interface link_stack_if #(
    parameter int AW = 10
);
    logic          branch;
    logic          jump2sub;
    logic          retFsub;
    logic [AW-1:0] rp;
    logic [AW-1:0] rl;
    logic [4:0]    depth;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          underflow;

    modport master (
        output branch, jump2sub, retFsub, rp,
        input  rl, depth, empty, full, overflow, underflow
    );

    modport slave (
        input  branch, jump2sub, retFsub, rp,
        output rl, depth, empty, full, overflow, underflow
    );
endinterface

// File: rtl/link_stack.sv
// Circular return-address stack beside the PC: pushes rp+1 on calls, presents and pops on returns.
module link_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic         clk,
    input  logic         start,
    link_stack_if.slave  bus
);
    localparam int            TW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TW-1:0] TOP_ONE   = TW'(1);
    localparam logic [4:0]    DEPTH_MAX = 5'(DEPTH);

    logic [AW-1:0] mem_r [DEPTH];
    logic [TW-1:0] top_r;
    logic [4:0]    depth_r;
    logic          overflow_r;
    logic          underflow_r;

    logic          push_s;
    logic          pop_s;
    logic [TW-1:0] top_inc_s;
    logic [TW-1:0] top_dec_s;
    logic [AW-1:0] ret_addr_s;
    logic [AW-1:0] rl_s;

    // Effective strobes follow the PC priority: start > branch > jump2sub > retFsub.
    always_comb begin
        push_s     = ~start & ~bus.branch & bus.jump2sub;
        pop_s      = ~start & ~bus.branch & ~bus.jump2sub & bus.retFsub;
        top_inc_s  = top_r + TOP_ONE;
        top_dec_s  = top_r - TOP_ONE;
        ret_addr_s = bus.rp + AW'(1);
    end

    // Stack state; a push while full overwrites the oldest slot because the pointer wraps.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            top_r       <= '0;
            depth_r     <= 5'd0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (push_s) begin
            top_r            <= top_inc_s;
            mem_r[top_inc_s] <= ret_addr_s;
            if (depth_r == DEPTH_MAX) begin
                overflow_r <= 1'b1;
            end else begin
                depth_r <= depth_r + 5'd1;
            end
        end else if (pop_s) begin
            if (depth_r == 5'd0) begin
                underflow_r <= 1'b1;
            end else begin
                top_r   <= top_dec_s;
                depth_r <= depth_r - 5'd1;
            end
        end else begin
            top_r <= top_r;
        end
    end

    // Zero-latency top-of-stack read so the PC can load rl on the pop edge.
    always_comb begin
        if (depth_r == 5'd0) begin
            rl_s = '0;
        end else begin
            rl_s = mem_r[top_r];
        end
    end

    // Output drive from registered state only.
    always_comb begin
        bus.rl        = rl_s;
        bus.depth     = depth_r;
        bus.empty     = (depth_r == 5'd0);
        bus.full      = (depth_r == DEPTH_MAX);
        bus.overflow  = overflow_r;
        bus.underflow = underflow_r;
    end
endmodule

// File: tb/tb_link_stack.sv
// Randomized and directed check of link_stack against a queue-based return-stack model.
module tb_link_stack;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic clk;
    logic start;

    link_stack_if #(.AW(AW)) bus ();

    link_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;

    // Reference: newest entry at the back, oldest dropped from the front when over capacity.
    int unsigned m_q[$];
    bit          m_ov;
    bit          m_un;
    bit          m_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_rl();
        if (m_q.size() == 0) return 0;
        return m_q[m_q.size()-1];
    endfunction

    task automatic check_all();
        if (m_valid) begin
            check_eq("rl",        32'(bus.rl),        model_rl());
            check_eq("depth",     32'(bus.depth),     m_q.size());
            check_eq("empty",     32'(bus.empty),     32'(m_q.size() == 0));
            check_eq("full",      32'(bus.full),      32'(m_q.size() == DEPTH));
            check_eq("overflow",  32'(bus.overflow),  32'(m_ov));
            check_eq("underflow", 32'(bus.underflow), 32'(m_un));
        end
    endtask

    // Called just after a negedge: drive, check current state, advance the model, wait one cycle.
    task automatic drive(input bit st, input bit b, input bit j, input bit r, input logic [AW-1:0] p);
        start        = st;
        bus.branch   = b;
        bus.jump2sub = j;
        bus.retFsub  = r;
        bus.rp       = p;
        check_all();
        if (st) begin
            m_q.delete();
            m_ov    = 1'b0;
            m_un    = 1'b0;
            m_valid = 1'b1;
        end else if (b) begin
            m_ov = m_ov;
        end else if (j) begin
            m_q.push_back((int'(p) + 1) % (1 << AW));
            if (m_q.size() > DEPTH) begin
                void'(m_q.pop_front());
                m_ov = 1'b1;
            end
        end else if (r) begin
            if (m_q.size() == 0) m_un = 1'b1;
            else void'(m_q.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        m_valid      = 1'b0;
        m_ov         = 1'b0;
        m_un         = 1'b0;
        start        = 1'b1;
        bus.branch   = 1'b0;
        bus.jump2sub = 1'b0;
        bus.retFsub  = 1'b0;
        bus.rp       = '0;
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 10'h155);
        idle();
        check_eq("rst_rl", 32'(bus.rl), 32'h0);
        check_eq("rst_empty", 32'(bus.empty), 32'h1);

        // Call then immediate return.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h012);
        check_eq("call_ret_rl", 32'(bus.rl), 32'h013);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h300);
        check_eq("call_ret_depth", 32'(bus.depth), 32'h0);

        // Nested calls.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h010);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h120);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h230);
        check_eq("nest_rl0", 32'(bus.rl), 32'h231);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h100);
        check_eq("nest_rl1", 32'(bus.rl), 32'h121);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h100);
        check_eq("nest_rl2", 32'(bus.rl), 32'h011);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h100);
        idle();

        // Overflow: five pushes into four slots, then drain.
        for (int i = 1; i <= 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, AW'(i));
        check_eq("ovf_full", 32'(bus.full), 32'h1);
        check_eq("ovf_flag", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check_eq("ovf_pop_rl", 32'(bus.rl), 32'(6 - i));
            drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        end
        idle();

        // Underflow then wraparound push.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        check_eq("unf_flag", 32'(bus.underflow), 32'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h3FF);
        check_eq("wrap_rl", 32'(bus.rl), 32'h000);
        check_eq("wrap_depth", 32'(bus.depth), 32'h1);

        // Priority cases and mid-operation reset.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h077);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 10'h077);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h040);
        check_eq("prio_rl", 32'(bus.rl), 32'h041);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 10'h050);
        check_eq("pre_rst_depth", 32'(bus.depth), 32'h3);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 10'h060);
        check_eq("post_rst_depth", 32'(bus.depth), 32'h0);
        check_eq("post_rst_ovf", 32'(bus.overflow), 32'h0);
        check_eq("post_rst_unf", 32'(bus.underflow), 32'h0);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  AW'($urandom));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
